reg_bridge: RTL and testbench

- MCU-side register bridge: parses byte frames from the MCU serial link, queues register writes, issues them to the cartridge mapper domain over the `wr_reg` / `wr_reg_addr` / `wr_reg_changed` toggle interface, and streams the `status_reg` snapshot back.
- Runs entirely on `clk`. The consumer synchronises the toggle on negedge M2, so the bridge holds each write stable for a programmable minimum interval.

---
 rtl/reg_bridge.sv | 247 ++++++++++++++++++++++++
 tb/tb_reg_bridge.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bridge.sv
// reg_bridge: MCU-side register bridge.
// Parses byte frames from the MCU serial link, queues register writes in a small
// FIFO, issues them to the mapper domain over a toggle handshake (each write held
// for HOLD_CYCLES), and streams a status_reg snapshot back on tx_data.
// Optional feature: define REG_BRIDGE_READBACK_EN to add a 16x12 shadow array of
// issued writes and the READ_SHADOW command (op 0x3).
module reg_bridge #(
    parameter int FIFO_DEPTH  = 4,    // power of two, >= 2
    parameter int HOLD_CYCLES = 256   // clk cycles each issued write is held
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    input  logic        tx_next,
    output logic [7:0]  tx_data,
    output logic [11:0] wr_reg,
    output logic [3:0]  wr_reg_addr,
    output logic        wr_reg_changed,
    input  logic [31:0] status_reg,
    output logic        overflow,
    output logic        busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int HW = $clog2(HOLD_CYCLES + 1);

    localparam logic [3:0] OP_WRITE       = 4'h1;
    localparam logic [3:0] OP_READ_STATUS = 4'h2;
`ifdef REG_BRIDGE_READBACK_EN
    localparam logic [3:0] OP_READ_SHADOW = 4'h3;
`endif

    typedef enum logic [2:0] {
        P_CMD,
        P_WR_HI,
        P_WR_LO,
        P_RD,
        P_DISCARD
    } pstate_e;

    typedef enum logic {
        I_IDLE,
        I_HOLD
    } istate_e;

    // Parser state
    pstate_e     pstate_q, pstate_d;
    logic [3:0]  addr_q, addr_d;
    logic [3:0]  hi_q, hi_d;
    logic [31:0] shift_q, shift_d;     // bytes still to be presented, MSB first
    logic [7:0]  tx_q, tx_d;
    logic        push;
    logic [15:0] push_data;

    // Write FIFO
    logic [15:0]   mem_q [FIFO_DEPTH];
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, pop, push_ok;
    logic [15:0]   head;

    // Issue side
    istate_e       istate_q, istate_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [11:0]   wr_reg_q, wr_reg_d;
    logic [3:0]    wr_addr_q, wr_addr_d;
    logic          tog_q, tog_d;
    logic          ovf_q, ovf_d;

`ifdef REG_BRIDGE_READBACK_EN
    logic [11:0] shadow_q [16];

    // Shadow copy of every issued write, readable through READ_SHADOW.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) shadow_q[i] <= '0;
        end else if (pop) begin
            shadow_q[head[15:12]] <= head[11:0];
        end
    end
`endif

    // Frame parser: command decode, write assembly and read-byte sequencing.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned,
        // which would otherwise infer a latch.
        pstate_d = pstate_q;
        addr_d   = addr_q;
        hi_d     = hi_q;
        shift_d  = shift_q;
        tx_d     = tx_q;
        push     = 1'b0;
        if (frame_start) begin
            // A new frame abandons any partial write and any read in progress.
            pstate_d = P_CMD;
            tx_d     = 8'h00;
        end else begin
            case (pstate_q)
                P_CMD: begin
                    if (rx_valid) begin
                        case (rx_data[7:4])
                            OP_WRITE: begin
                                addr_d   = rx_data[3:0];
                                pstate_d = P_WR_HI;
                            end
                            OP_READ_STATUS: begin
                                tx_d     = status_reg[31:24];
                                shift_d  = {status_reg[23:0], 8'h00};
                                pstate_d = P_RD;
                            end
`ifdef REG_BRIDGE_READBACK_EN
                            OP_READ_SHADOW: begin
                                tx_d     = {4'h0, shadow_q[rx_data[3:0]][11:8]};
                                shift_d  = {shadow_q[rx_data[3:0]][7:0], 24'h000000};
                                pstate_d = P_RD;
                            end
`endif
                            default: pstate_d = P_DISCARD;
                        endcase
                    end
                end
                P_WR_HI: begin
                    if (rx_valid) begin
                        hi_d     = rx_data[3:0];
                        pstate_d = P_WR_LO;
                    end
                end
                P_WR_LO: begin
                    if (rx_valid) begin
                        push     = 1'b1;
                        pstate_d = P_CMD;
                    end
                end
                P_RD: begin
                    // Once the snapshot is exhausted the shifter supplies zeros.
                    if (tx_next) begin
                        tx_d    = shift_q[31:24];
                        shift_d = {shift_q[23:0], 8'h00};
                    end
                end
                default: ;  // P_DISCARD: wait for the next frame_start
            endcase
        end
    end

    assign push_data = {addr_q, hi_q, rx_data};

    // FIFO bookkeeping: a push on a full FIFO only succeeds if a pop frees a slot.
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign pop     = (istate_q == I_IDLE) && !empty;
    assign push_ok = push && (!full || pop);
    assign head    = mem_q[rptr_q];

    // Pointer, occupancy and sticky overflow next-state.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (push_ok) wptr_d = wptr_q + 1'b1;
        if (pop)     rptr_d = rptr_q + 1'b1;
        if (push_ok && !pop)      count_d = count_q + 1'b1;
        else if (!push_ok && pop) count_d = count_q - 1'b1;
        if (push && !push_ok)     ovf_d = 1'b1;
    end

    // FIFO storage.
    // NOTE: the data array carries no reset; occupancy is tracked by the pointers,
    // so stale contents are never observed and the array can map to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wptr_q] <= push_data;
    end

    // Issue FSM: pop, present and toggle, then hold for HOLD_CYCLES.
    always_comb begin
        istate_d  = istate_q;
        hold_d    = hold_q;
        wr_reg_d  = wr_reg_q;
        wr_addr_d = wr_addr_q;
        tog_d     = tog_q;
        case (istate_q)
            I_IDLE: begin
                if (!empty) begin
                    wr_reg_d  = head[11:0];
                    wr_addr_d = head[15:12];
                    tog_d     = ~tog_q;
                    hold_d    = HW'(HOLD_CYCLES - 1);
                    istate_d  = I_HOLD;
                end
            end
            default: begin
                if (hold_q == '0) istate_d = I_IDLE;
                else              hold_d   = hold_q - 1'b1;
            end
        endcase
    end

    // State registers for parser, FIFO pointers and issue side.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q  <= P_CMD;
            addr_q    <= '0;
            hi_q      <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            wptr_q    <= '0;
            rptr_q    <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            istate_q  <= I_IDLE;
            hold_q    <= '0;
            wr_reg_q  <= '0;
            wr_addr_q <= '0;
            tog_q     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            pstate_q  <= pstate_d;
            addr_q    <= addr_d;
            hi_q      <= hi_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            istate_q  <= istate_d;
            hold_q    <= hold_d;
            wr_reg_q  <= wr_reg_d;
            wr_addr_q <= wr_addr_d;
            tog_q     <= tog_d;
        end
    end

    assign tx_data        = tx_q;
    assign wr_reg         = wr_reg_q;
    assign wr_reg_addr    = wr_addr_q;
    assign wr_reg_changed = tog_q;
    assign overflow       = ovf_q;
    assign busy           = !empty || (istate_q == I_HOLD);

endmodule

// File: tb/tb_reg_bridge.sv
// tb_reg_bridge: directed and randomized bench for reg_bridge, checked every
// cycle against a transaction-level model (byte queues and a write queue with
// issue timestamps), plus literal expectations from hand-worked scenarios.
`timescale 1ns/1ps
module tb_reg_bridge;

    localparam int DEPTH = 4;
    localparam int HOLD  = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        tx_next = 1'b0;
    logic [31:0] status_reg = 32'h0;
    logic [7:0]  tx_data;
    logic [11:0] wr_reg;
    logic [3:0]  wr_reg_addr;
    logic        wr_reg_changed;
    logic        overflow;
    logic        busy;

    reg_bridge #(.FIFO_DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .frame_start    (frame_start),
        .rx_valid       (rx_valid),
        .rx_data        (rx_data),
        .tx_next        (tx_next),
        .tx_data        (tx_data),
        .wr_reg         (wr_reg),
        .wr_reg_addr    (wr_reg_addr),
        .wr_reg_changed (wr_reg_changed),
        .status_reg     (status_reg),
        .overflow       (overflow),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef enum {M_CMD, M_HI, M_LO, M_READ, M_DISCARD} mmode_e;

    mmode_e      m_mode;
    logic [3:0]  m_waddr, m_whi;
    logic [7:0]  m_tx;
    logic [7:0]  m_txq[$];      // bytes still to be shifted out
    logic [15:0] m_q[$];        // pending writes {addr, value}
    int          hold_end;      // busy-hold lasts while cyc < hold_end
    logic [11:0] m_wr;
    logic [3:0]  m_addr;
    logic        m_tog, m_ovf;
    logic [11:0] m_shadow[16];
    int          cyc = 0;

    task automatic model_reset();
        m_mode   = M_CMD;
        m_waddr  = '0;
        m_whi    = '0;
        m_tx     = 8'h00;
        m_txq.delete();
        m_q.delete();
        hold_end = -1;
        m_wr     = '0;
        m_addr   = '0;
        m_tog    = 1'b0;
        m_ovf    = 1'b0;
        for (int i = 0; i < 16; i++) m_shadow[i] = '0;
    endtask

    task automatic model_step();
        int          pre;
        bit          do_pop, do_push;
        logic [15:0] ent, pent;
        cyc++;
        pre     = m_q.size();
        do_pop  = (pre != 0) && (cyc > hold_end);
        do_push = 0;
        pent    = '0;
        if (frame_start) begin
            m_mode = M_CMD;
            m_tx   = 8'h00;
            m_txq.delete();
        end else begin
            case (m_mode)
                M_CMD: if (rx_valid) begin
                    case (rx_data[7:4])
                        4'h1: begin m_waddr = rx_data[3:0]; m_mode = M_HI; end
                        4'h2: begin
                            m_txq.delete();
                            for (int k = 3; k >= 0; k--) m_txq.push_back(status_reg[8*k +: 8]);
                            m_tx   = m_txq.pop_front();
                            m_mode = M_READ;
                        end
`ifdef REG_BRIDGE_READBACK_EN
                        4'h3: begin
                            m_txq.delete();
                            m_txq.push_back({4'h0, m_shadow[rx_data[3:0]][11:8]});
                            m_txq.push_back(m_shadow[rx_data[3:0]][7:0]);
                            m_tx   = m_txq.pop_front();
                            m_mode = M_READ;
                        end
`endif
                        default: m_mode = M_DISCARD;
                    endcase
                end
                M_HI: if (rx_valid) begin m_whi = rx_data[3:0]; m_mode = M_LO; end
                M_LO: if (rx_valid) begin
                    do_push = 1;
                    pent    = {m_waddr, m_whi, rx_data};
                    m_mode  = M_CMD;
                end
                M_READ: if (tx_next) begin
                    if (m_txq.size() != 0) m_tx = m_txq.pop_front();
                    else                   m_tx = 8'h00;
                end
                default: ;
            endcase
        end
        if (do_pop) begin
            ent      = m_q.pop_front();
            m_wr     = ent[11:0];
            m_addr   = ent[15:12];
            m_tog    = ~m_tog;
            hold_end = cyc + HOLD;
            m_shadow[ent[15:12]] = ent[11:0];
        end
        if (do_push) begin
            if (pre == DEPTH && !do_pop) m_ovf = 1'b1;
            else                         m_q.push_back(pent);
        end
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    // ---------------- per-cycle compare and event monitor ----------------
    int   tog_cnt = 0;
    int   last_tog_cyc = 0, prev_tog_cyc = 0;
    int   busy_cnt = 0;
    logic prev_tog = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            check("tx_data",        tx_data,        m_tx);
            check("wr_reg",         wr_reg,         m_wr);
            check("wr_reg_addr",    wr_reg_addr,    m_addr);
            check("wr_reg_changed", wr_reg_changed, m_tog);
            check("overflow",       overflow,       m_ovf);
            check("busy",           busy,           (m_q.size() != 0) || (cyc < hold_end));
            if (rst_n) begin
                if (wr_reg_changed !== prev_tog) begin
                    tog_cnt++;
                    prev_tog_cyc = last_tog_cyc;
                    last_tog_cyc = cyc;
                end
                if (busy) busy_cnt++;
            end
            prev_tog = wr_reg_changed;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame();
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic txn();
        tx_next = 1'b1;
        tick();
        tx_next = 1'b0;
    endtask

    task automatic wait_tog(input int target, input int budget);
        int n = 0;
        while (tog_cnt < target && n < budget) begin
            tick();
            n++;
        end
        tick();
        check("toggle_wait", tog_cnt >= target, 1);
    endtask

    // ---------------- test sequence ----------------
    logic [7:0] rd_exp [6];
    int t0;
    int r;

    initial begin
        rd_exp = '{8'h00, 8'h00, 8'h03, 8'hA5, 8'h00, 8'h00};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        check("rst_tx_data",  tx_data,        8'h00);
        check("rst_wr_reg",   wr_reg,         12'h000);
        check("rst_changed",  wr_reg_changed, 1'b0);
        check("rst_overflow", overflow,       1'b0);
        check("rst_busy",     busy,           1'b0);

        // Single write: addr 0, value 0xA45.
        busy_cnt = 0;
        t0 = tog_cnt;
        frame();
        send(8'h10); send(8'h0A); send(8'h45);
        wait_tog(t0 + 1, 10);
        check("w1_value",   wr_reg,         12'hA45);
        check("w1_addr",    wr_reg_addr,    4'h0);
        check("w1_changed", wr_reg_changed, 1'b1);
        idle(2 * HOLD);
        check("w1_busy_cycles", busy_cnt, HOLD + 1);

        // Two writes in one frame.
        t0 = tog_cnt;
        frame();
        send(8'h11); send(8'h00); send(8'h0F);
        send(8'h12); send(8'h0F); send(8'hFF);
        wait_tog(t0 + 2, 3 * HOLD);
        check("w2_spacing", last_tog_cyc - prev_tog_cyc, HOLD + 1);
        check("w2_value",   wr_reg,      12'hFFF);
        check("w2_addr",    wr_reg_addr, 4'h2);
        idle(HOLD + 5);

        // Status read, with status_reg changing after the command byte.
        status_reg = 32'h000003A5;
        frame();
        send(8'h20);
        status_reg = 32'hDEADBEEF;
        check("rd_byte0", tx_data, rd_exp[0]);
        for (int i = 1; i < 6; i++) begin
            txn();
            check($sformatf("rd_byte%0d", i), tx_data, rd_exp[i]);
        end
        frame();
        check("rd_exit_zero", tx_data, 8'h00);

        // Overflow: DEPTH+2 writes faster than they drain.
        t0 = tog_cnt;
        frame();
        for (int i = 0; i < DEPTH + 2; i++) begin
            send({4'h1, 4'(i)});
            send(8'(i));
            send(8'(i * 3));
        end
        check("ovf_set", overflow, 1'b1);
        idle((DEPTH + 2) * (HOLD + 1) + 10);
        check("ovf_toggles", tog_cnt - t0, DEPTH + 1);
        check("ovf_sticky",  overflow, 1'b1);
        check("ovf_drained", busy, 1'b0);

        // Aborted write, then a full write, then an unknown op with trailing bytes.
        t0 = tog_cnt;
        frame();
        send(8'h13); send(8'h05);
        frame();
        send(8'h14); send(8'h01); send(8'h23);
        frame();
        send(8'h70); send(8'h11); send(8'h22); send(8'h33);
        wait_tog(t0 + 1, 20);
        idle(2 * HOLD);
        check("abort_toggles", tog_cnt - t0, 1);
        check("abort_value",   wr_reg,      12'h123);
        check("abort_addr",    wr_reg_addr, 4'h4);

        // Reset during HOLD with entries queued.
        frame();
        send(8'h15); send(8'h01); send(8'h11);
        send(8'h16); send(8'h02); send(8'h22);
        send(8'h17); send(8'h03); send(8'h33);
        check("pre_reset_busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        check("arst_wr_reg",   wr_reg,         12'h000);
        check("arst_addr",     wr_reg_addr,    4'h0);
        check("arst_changed",  wr_reg_changed, 1'b0);
        check("arst_overflow", overflow,       1'b0);
        check("arst_busy",     busy,           1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        t0 = tog_cnt;
        idle(4 * HOLD);
        check("post_reset_toggles", tog_cnt - t0, 0);
        check("post_reset_busy",    busy, 1'b0);

        // Randomized traffic, checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            frame_start = ($urandom_range(0, 19) == 0);
            rx_valid    = ($urandom_range(0, 2) == 0);
            r = $urandom_range(0, 9);
            if (r < 4)      rx_data = {4'h1, 4'($urandom)};
            else if (r < 6) rx_data = {4'h2, 4'($urandom)};
            else if (r < 7) rx_data = {4'h3, 4'($urandom)};
            else            rx_data = 8'($urandom);
            tx_next    = ($urandom_range(0, 3) == 0);
            status_reg = $urandom;
            tick();
        end
        frame_start = 1'b0;
        rx_valid    = 1'b0;
        tx_next     = 1'b0;
        idle((DEPTH + 2) * (HOLD + 1) + 10);
        check("final_drained", busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
